// File: rtl/sigma_delta_decoder_if.sv
// rtl/sigma_delta_decoder_if.sv - bitstream in / PCM out bundle for the sigma-delta decoder
// The sat member exists only when SIGMA_DELTA_DECODER_SAT_EN is defined.
interface sigma_delta_decoder_if #(
  parameter int OUT_WIDTH = 16
);
  logic                        din;
  logic                        din_valid;
  logic signed [OUT_WIDTH-1:0] dout;
  logic                        dout_valid;
`ifdef SIGMA_DELTA_DECODER_SAT_EN
  logic                        sat;

  modport master (output din, output din_valid, input dout, input dout_valid, input sat);
  modport slave  (input din, input din_valid, output dout, output dout_valid, output sat);
`else
  modport master (output din, output din_valid, input dout, input dout_valid);
  modport slave  (input din, input din_valid, output dout, output dout_valid);
`endif
endinterface

// File: rtl/sigma_delta_decoder.sv
// rtl/sigma_delta_decoder.sv - 3rd-order CIC decimator turning a 1-bit delta-sigma stream into signed PCM
// Defining SIGMA_DELTA_DECODER_SAT_EN adds a registered sat flag for clamped output words.
module sigma_delta_decoder #(
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sigma_delta_decoder_if.slave bus
);
  localparam int L     = $clog2(DECIM);
  localparam int W     = 2 + 3 * L;
  localparam int SHIFT = 3 * L - (OUT_WIDTH - 1);
  localparam int HW    = W - OUT_WIDTH + 1;

  logic [W-1:0]                i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [L-1:0]                cnt_q, cnt_d;
  logic                        stb1_q, stb1_d, stb2_q, stb2_d, stb3_q, stb3_d;
  logic [W-1:0]                s_prev_q, s_prev_d, c1_q, c1_d;
  logic [W-1:0]                c1_prev_q, c1_prev_d, c2_prev_q, c2_prev_d, c3_q, c3_d;
  logic [1:0]                  warm_q, warm_d;
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic [W-1:0]                x, c2;
  logic signed [W-1:0]         y;
  logic [HW-1:0]               y_hi;
  logic                        clamped;
  logic signed [OUT_WIDTH-1:0] y_sat;
`ifdef SIGMA_DELTA_DECODER_SAT_EN
  logic                        sat_q, sat_d;
`endif

  // After the shift the word needs OUT_WIDTH+1 bits; it fits iff the top HW bits agree.
  always_comb begin
    y       = $signed(c3_q) >>> SHIFT;
    y_hi    = y[W-1:OUT_WIDTH-1];
    clamped = !((y_hi == '0) || (y_hi == '1));
    if (!clamped) begin
      y_sat = y[OUT_WIDTH-1:0];
    end else if (y[W-1]) begin
      y_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    i1_d         = i1_q;
    i2_d         = i2_q;
    i3_d         = i3_q;
    cnt_d        = cnt_q;
    s_prev_d     = s_prev_q;
    c1_d         = c1_q;
    c1_prev_d    = c1_prev_q;
    c2_prev_d    = c2_prev_q;
    c3_d         = c3_q;
    warm_d       = warm_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    x            = bus.din ? W'(1) : {W{1'b1}};
    c2           = c1_q - c1_prev_q;
    stb1_d       = bus.din_valid && (cnt_q == L'(DECIM - 1));
    stb2_d       = stb1_q;
    stb3_d       = stb2_q;
`ifdef SIGMA_DELTA_DECODER_SAT_EN
    sat_d        = 1'b0;
`endif

    // Integrators wrap modulo 2^W on purpose; the combs cancel the wrap exactly.
    if (bus.din_valid) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_d;
      i3_d  = i3_q + i2_d;
      cnt_d = cnt_q + L'(1);
    end

    if (stb1_q) begin
      c1_d     = i3_q - s_prev_q;
      s_prev_d = i3_q;
    end

    if (stb2_q) begin
      c3_d      = c2 - c2_prev_q;
      c1_prev_d = c1_q;
      c2_prev_d = c2;
    end

    // The first two decimated words only prime the comb delays and are never shown.
    if (stb3_q) begin
      if (warm_q == 2'd2) begin
        dout_d       = y_sat;
        dout_valid_d = 1'b1;
`ifdef SIGMA_DELTA_DECODER_SAT_EN
        sat_d        = clamped;
`endif
      end else begin
        warm_d = warm_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      cnt_q        <= '0;
      stb1_q       <= 1'b0;
      stb2_q       <= 1'b0;
      stb3_q       <= 1'b0;
      s_prev_q     <= '0;
      c1_q         <= '0;
      c1_prev_q    <= '0;
      c2_prev_q    <= '0;
      c3_q         <= '0;
      warm_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef SIGMA_DELTA_DECODER_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      cnt_q        <= cnt_d;
      stb1_q       <= stb1_d;
      stb2_q       <= stb2_d;
      stb3_q       <= stb3_d;
      s_prev_q     <= s_prev_d;
      c1_q         <= c1_d;
      c1_prev_q    <= c1_prev_d;
      c2_prev_q    <= c2_prev_d;
      c3_q         <= c3_d;
      warm_q       <= warm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef SIGMA_DELTA_DECODER_SAT_EN
      sat_q        <= sat_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`ifdef SIGMA_DELTA_DECODER_SAT_EN
  assign bus.sat        = sat_q;
`endif

endmodule

// File: tb/tb_sigma_delta_decoder.sv
// tb/tb_sigma_delta_decoder.sv - scoreboard bench for sigma_delta_decoder against a cascaded moving-sum model
module tb_sigma_delta_decoder;
  localparam int DECIM     = 64;
  localparam int OUT_WIDTH = 16;
  localparam int SH        = 3 * $clog2(DECIM) - (OUT_WIDTH - 1);
  localparam int YMAX      = (1 << (OUT_WIDTH - 1)) - 1;
  localparam int YMIN      = -(1 << (OUT_WIDTH - 1));
  localparam int HMAX      = 8192;

  typedef struct {
    int val;
    int sat;
    int at_edge;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sigma_delta_decoder_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

  sigma_delta_decoder #(.DECIM(DECIM), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_cnt = 0;
  int   pulse_cnt = 0;
  int   last_dout = 0;
  exp_t exp_q[$];
  exp_t e;

  // Reference: three cascaded length-DECIM moving sums of the +/-1 input history.
  int xh[HMAX];
  int a1[HMAX];
  int a2[HMAX];
  int a3[HMAX];
  int nb = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic model_bit(input logic b, input int at_edge);
    int n, y;
    exp_t t;
    n = nb;
    xh[n] = b ? 1 : -1;
    a1[n] = ((n > 0) ? a1[n-1] : 0) + xh[n] - ((n >= DECIM) ? xh[n-DECIM] : 0);
    a2[n] = ((n > 0) ? a2[n-1] : 0) + a1[n] - ((n >= DECIM) ? a1[n-DECIM] : 0);
    a3[n] = ((n > 0) ? a3[n-1] : 0) + a2[n] - ((n >= DECIM) ? a2[n-DECIM] : 0);
    nb++;
    if ((nb % DECIM) == 0 && (nb / DECIM) >= 3) begin
      y = a3[n] >>> SH;
      t.sat = 0;
      if (y > YMAX) begin y = YMAX; t.sat = 1; end
      if (y < YMIN) begin y = YMIN; t.sat = 1; end
      t.val = y;
      t.at_edge = at_edge;
      exp_q.push_back(t);
    end
  endtask

  task automatic drive(input logic v, input logic b);
    @(posedge clk);
    #1;
    bus.din_valid = v;
    bus.din       = b;
    if (v) model_bit(b, edge_cnt + 4);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    bus.din_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("async_reset_dout", int'($signed(bus.dout)), 0);
    check("async_reset_valid", int'(bus.dout_valid), 0);
    check("pending_at_reset", exp_q.size(), 0);
    exp_q.delete();
    nb = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic run(input logic [3:0] pat, input int plen, input int nbits, input bit gap);
    for (int k = 0; k < nbits; k++) begin
      drive(1'b1, pat[k % plen]);
      if (gap) drive(1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every output pulse and flags missing or stray pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dout_valid) begin
        pulse_cnt++;
        last_dout = int'($signed(bus.dout));
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dout", int'($signed(bus.dout)), e.val);
          check("latency_edge", edge_cnt, e.at_edge);
`ifdef SIGMA_DELTA_DECODER_SAT_EN
          check("sat", int'(bus.sat), e.sat);
`endif
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
          check("missing_pulse", edge_cnt, exp_q[0].at_edge);
          void'(exp_q.pop_front());
        end
`ifdef SIGMA_DELTA_DECODER_SAT_EN
        if (bus.sat) check("sat_idle", 1, 0);
`endif
      end
    end
  end

  initial begin
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    reset         = 1'b1;
    #2;
    check("reset_dout", int'($signed(bus.dout)), 0);
    check("reset_valid", int'(bus.dout_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    run(4'b1111, 1, 5 * DECIM, 1'b0);
    drain();
    check("ones_pulses", pulse_cnt, 3);
    check("ones_value", last_dout, 32767);

    do_reset();
    run(4'b0000, 1, 5 * DECIM, 1'b0);
    drain();
    check("zeros_pulses", pulse_cnt, 3);
    check("zeros_value", last_dout, -32768);

    do_reset();
    run(4'b0101, 2, 4 * DECIM, 1'b0);
    drain();
    check("alt_pulses", pulse_cnt, 2);
    check("alt_value", last_dout, 0);

    do_reset();
    run(4'b0111, 4, 4 * DECIM, 1'b0);
    drain();
    check("duty75_pulses", pulse_cnt, 2);
    check("duty75_value", last_dout, 16384);
    run(4'b0111, 4, 40, 1'b0);
    do_reset();
    run(4'b0111, 4, 3 * DECIM, 1'b0);
    drain();
    check("after_reset_pulses", pulse_cnt, 1);
    check("after_reset_value", last_dout, 16384);

    do_reset();
    run(4'b1111, 1, 4 * DECIM, 1'b1);
    drain();
    check("gapped_pulses", pulse_cnt, 2);
    check("gapped_value", last_dout, 32767);

    do_reset();
    begin
      int p;
      p = 50;
      for (int k = 0; k < 2200; k++) begin
        if (k % 200 == 0) p = $urandom_range(0, 100);
        drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0);
      end
    end
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sigma_delta_decoder.md
Name: sigma_delta_decoder

Overview:
- Decodes a 1-bit delta-sigma bitstream into signed PCM words. It is the inverse of the DAC delta-sigma modulator.
- Structure: 3rd-order CIC decimator with integrators, decimation counter and combs, followed by scaling and saturation.
- Uses: loopback-checks the DAC output path in the receiver chain, and is the front end for any future 1-bit delta-sigma ADC input.
- Runs in the sample clock domain (16 MHz) alongside the AM detector.

Parameters:
- DECIM, 64: decimation ratio. Power of two, legal range 32..256.
- OUT_WIDTH, 16: output word width, signed.
- Derived L = log2(DECIM).
- Derived W = 2 + 3*L: internal register width (20 for the defaults).
- Derived SHIFT = 3*L - (OUT_WIDTH-1): must be >= 0.

Ports:
- clk  in  1  sample clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  1  bitstream input; 1 means +1, 0 means -1.
- din_valid  in  1  qualifies din; one bit is accepted per clk edge where din_valid=1.
- dout  out  OUT_WIDTH  signed decoded sample, registered.
- dout_valid  out  1  one-cycle pulse; dout is valid in that cycle.

Behaviour:
- Reset (async, immediate) clears the following to 0: integrators I1..I3, comb delay registers, decimation counter, warm-up counter, pipeline registers, dout, dout_valid.
- Input mapping: x = +1 when din=1, x = -1 when din=0, sign-extended to W bits.
- Integrators update only on accepted bits: I1 += x, I2 += I1(new), I3 += I2(new).
  - All additions are modulo 2^W. Wrap-around is intentional and must not be saturated or flagged; the combs cancel it exactly.
- Decimation counter: 0..DECIM-1, increments per accepted bit, wraps from DECIM-1 to 0.
  - On the accepted bit with count = DECIM-1, decim_strobe is registered for the next cycle.
  - din_valid=0 freezes both the counter and the integrators.
- Pipeline, measured from edge N (the edge accepting the DECIM-th bit):
  - Edge N+1: S = I3 captured; C1 = S - S_prev.
  - Edge N+2: C2 = C1 - C1_prev; C3 = C2 - C2_prev.
  - Edge N+3: dout and dout_valid registered.
  - Fixed latency of 3 clk edges. Comb delay registers advance only on decimation strobes.
  - Accepted bits arriving while the pipeline is busy are processed normally; the integrators never stall.
- Scaling: y = C3 >>> SHIFT (arithmetic shift). Full scale ±2^(3L) maps to ±2^(OUT_WIDTH-1).
- Saturation: y > 2^(OUT_WIDTH-1)-1 gives 32767 (default width). y < -2^(OUT_WIDTH-1) cannot occur but is clamped anyway.
- Warm-up: the first 2 decimated outputs after reset are computed but dout_valid stays 0.
  - The first dout_valid comes after 3*DECIM accepted bits plus 3 edges.
  - The warm-up counter saturates at 2.
- dout holds its value between pulses. Warm-up values are not driven onto dout; dout stays 0 until the first valid output.
- Reset mid-operation: all state is cleared at once. A partial decimation window is discarded and warm-up restarts.
- din_valid held high for consecutive cycles: 1 bit per cycle, no throughput limit.

Optional Feature:
- Macro SIGMA_DELTA_DECODER_SAT_EN.
- When defined, adds output port `sat` (1 bit).
  - sat is registered alongside dout and is high exactly when the current dout_valid word was clamped.
  - sat resets to 0 and equals 0 whenever dout_valid=0.
- When undefined: no `sat` port and no flag logic; saturation still happens unconditionally.

Test Plan:
- All-ones stream, din_valid=1 constant, DECIM=64 -> first dout_valid after 192 bits + 3 edges; dout=32767 on every pulse; pulses every 64 cycles; sat=1 when the macro is defined.
- All-zeros stream -> dout=-32768 on every valid pulse; sat=0.
- Alternating 1,0,1,0 -> dout=0 on every valid pulse.
- Repeating 1,1,1,0 (75% duty) -> dout=16384 on every valid pulse after warm-up.
- All-ones stream with din_valid high every other cycle -> the same dout values as the first scenario; dout_valid spacing 128 cycles; no pulse in any window with fewer than 64 accepted bits.
- Assert reset asynchronously (between edges) after 40 bits of the 1,1,1,0 pattern, release, resume -> dout and dout_valid go to 0 without waiting for a clock edge; the next dout_valid comes after 192 more accepted bits + 3 edges, with dout=16384.
